// File: rtl/fetch_ir_unit.sv
// rtl/fetch_ir_unit.sv - PC register, instruction fetch handshake and IR decode
//
// Purpose:
//   Holds the program counter and the instruction register of a multicycle
//   core. A fetch requested by the control FSM (IRWrite) runs a two-state
//   handshake against instruction memory. While the fetch is outstanding,
//   stall freezes the control FSM. The IR fields are decoded
//   combinationally.
//
// Optional feature (macro FETCH_TIMEOUT_EN):
//   When this macro is defined, a fetch that sees no mem_ready for 16
//   consecutive WAIT cycles is abandoned. The fetch then loads a NOP
//   (0x00000000) and sets the sticky fetch_err flag.
//   When the macro is undefined, the unit waits forever and fetch_err is 0.
//
// Ports:
//   clk         in   1   clock, rising edge
//   reset       in   1   asynchronous, active-low reset
//   PCWrite     in   1   PC load request
//   IRWrite     in   1   fetch / IR load request
//   PCSrc       in   1   next-PC select: 0 alu_result, 1 alu_out
//   alu_result  in  32   combinational ALU output
//   alu_out     in  32   registered ALUOut value
//   mem_req     out  1   fetch request, high exactly in WAIT
//   mem_addr    out 32   fetch address (= pc)
//   mem_rdata   in  32   memory read data
//   mem_ready   in   1   memory completion strobe
//   stall       out  1   freeze request to control FSM
//   pc          out 32   program counter
//   instr       out 32   instruction register
//   Op/funct    out  6   instr[31:26] / instr[5:0]
//   rs/rt/rd    out  5   instr[25:21] / instr[20:16] / instr[15:11]
//   imm_sext    out 32   sign-extended instr[15:0]
//   fetch_err   out  1   sticky fetch-timeout flag

module fetch_ir_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IRWrite,
  input  logic        PCSrc,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  Op,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm_sext,
  output logic        fetch_err
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state;
  logic        fetch_done;
  logic        timeout_hit;
  logic        fetch_end;
  logic        pc_en;
  logic [31:0] next_pc;

  // The memory result is only looked at while a fetch is outstanding.
  // Strobes that arrive in IDLE are dropped.
  assign fetch_done = (state == WAIT) && mem_ready;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] tmo_cnt;
  logic       err_q;

  // The counter holds 15 during the 16th consecutive WAIT cycle without
  // mem_ready. If mem_ready arrives in that same cycle, the normal
  // completion wins.
  assign timeout_hit = (state == WAIT) && !mem_ready && (tmo_cnt == 4'hF);

  // The counter sits at zero in IDLE, so every fetch starts counting from a
  // cleared value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= 4'h0;
    end else if (state == IDLE) begin
      tmo_cnt <= 4'h0;
    end else if (!mem_ready) begin
      tmo_cnt <= tmo_cnt + 4'h1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  assign fetch_end = fetch_done || timeout_hit;

  // The control FSM is held for as long as it requests a fetch that has not
  // finished yet. An abandoned (timed-out) fetch also counts as finished.
  assign stall = IRWrite && !fetch_end;

  // pc must not move while the memory is being addressed. Inside WAIT, the
  // only edge that may load pc is the one that ends the fetch.
  assign pc_en   = PCWrite && !stall && ((state == IDLE) || fetch_end);
  assign next_pc = PCSrc ? alu_out : alu_result;

  // Handshake FSM. mem_req is a register that is kept in step with state,
  // so the memory sees a glitch-free request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      mem_req <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IRWrite) begin
            state   <= WAIT;
            mem_req <= 1'b1;
          end
        end
        WAIT: begin
          if (fetch_end) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= 32'h0000_0000;
    end else if (pc_en) begin
      pc <= next_pc;
    end
  end

  // The IR only changes while the control FSM still asks for the fetch.
  // A completion after IRWrite has dropped ends the handshake but leaves
  // the IR unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr <= 32'h0000_0000;
    end else if (IRWrite && fetch_done) begin
      instr <= mem_rdata;
    end else if (IRWrite && timeout_hit) begin
      instr <= 32'h0000_0000;
    end
  end

  assign mem_addr = pc;

  assign Op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};

endmodule

// File: tb/tb_fetch_ir_unit.sv
// tb/tb_fetch_ir_unit.sv - directed self-checking bench for fetch_ir_unit

module tb_fetch_ir_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, IRWrite, PCSrc;
  logic [31:0] alu_result, alu_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic [31:0] pc, instr;
  logic [5:0]  Op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  logic        fetch_err;

  int n_cmp = 0;
  int n_err = 0;

`ifdef FETCH_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  always #5 clk = ~clk;

  fetch_ir_unit dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .PCSrc(PCSrc), .alu_result(alu_result), .alu_out(alu_out),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .stall(stall), .pc(pc), .instr(instr),
    .Op(Op), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .imm_sext(imm_sext), .fetch_err(fetch_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: wait_n = 0 when no fetch is outstanding, otherwise the number of
  // the WAIT cycle the fetch is currently in (1 = first).
  int          m_wait_n;
  logic [31:0] m_pc, m_instr;
  bit          m_err;

  function automatic bit m_done();
    return (m_wait_n > 0) && mem_ready;
  endfunction

  function automatic bit m_tmo();
    return TMO && (m_wait_n == 16) && !mem_ready;
  endfunction

  always @(posedge clk or negedge reset) begin
    bit done, tmo, stl;
    if (!reset) begin
      m_wait_n = 0; m_pc = 0; m_instr = 0; m_err = 0;
    end else begin
      done = m_done();
      tmo  = m_tmo();
      stl  = IRWrite && !done && !tmo;
      if (PCWrite && !stl && (m_wait_n == 0 || done || tmo))
        m_pc = PCSrc ? alu_out : alu_result;
      if (IRWrite && done) m_instr = mem_rdata;
      else if (IRWrite && tmo) m_instr = 0;
      if (tmo) m_err = 1;
      if (m_wait_n == 0) m_wait_n = IRWrite ? 1 : 0;
      else if (done || tmo) m_wait_n = 0;
      else m_wait_n = m_wait_n + 1;
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    logic [31:0] lo;
    lo = m_instr % 65536;
    check("mem_req",   mem_req,   (m_wait_n > 0) ? 1 : 0);
    check("mem_addr",  mem_addr,  m_pc);
    check("pc",        pc,        m_pc);
    check("instr",     instr,     m_instr);
    check("stall",     stall,     (IRWrite && !m_done() && !m_tmo()) ? 1 : 0);
    check("fetch_err", fetch_err, m_err);
    check("Op",        Op,        m_instr / 67108864);
    check("rs",        rs,        (m_instr / 2097152) % 32);
    check("rt",        rt,        (m_instr / 65536) % 32);
    check("rd",        rd,        (m_instr / 2048) % 32);
    check("funct",     funct,     m_instr % 64);
    check("imm_sext",  imm_sext,  (lo >= 32768) ? lo + 32'hFFFF0000 : lo);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PCWrite = 0; IRWrite = 0; mem_ready = 0;
  endtask

  initial begin
    int stall_hi;
    int req_cnt;
    reset = 0; PCSrc = 0; alu_result = 0; alu_out = 0; mem_rdata = 0;
    idle_inputs();
    IRWrite = 1;
    #2;
    check("rst_stall_follows_irwrite", stall, 1);
    check("rst_mem_req", mem_req, 0);
    IRWrite = 0;
    step(); step();
    check("rst_pc", pc, 0);
    check("rst_instr", instr, 0);
    check("rst_op", Op, 0);
    check("rst_imm", imm_sext, 0);
    check("rst_err", fetch_err, 0);
    reset = 1;

    // Minimum-latency fetch with PC+4.
    step();
    IRWrite = 1; PCWrite = 1; PCSrc = 0; alu_result = 32'h4;
    #1 stall_hi = int'(stall);
    step();
    mem_ready = 1; mem_rdata = 32'h2009_0005;
    #1 stall_hi += int'(stall);
    check("f1_mem_req", mem_req, 1);
    step();
    idle_inputs();
    #1;
    check("f1_instr", instr, 32'h2009_0005);
    check("f1_op", Op, 32'h08);
    check("f1_rt", rt, 9);
    check("f1_imm", imm_sext, 32'h5);
    check("f1_pc", pc, 32'h4);
    check("f1_stall_cycles", stall_hi, 1);

    // Reset pulse, then a fetch that waits three cycles.
    reset = 0; #1 reset = 1;
    IRWrite = 1; PCWrite = 1; PCSrc = 0; alu_result = 32'h4;
    req_cnt = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      if (i == 3) begin mem_ready = 1; mem_rdata = 32'h0000_FFFF; end
      #1;
      req_cnt += int'(mem_req);
      check("f2_addr_const", mem_addr, 32'h0);
      check("f2_pc_held", pc, 32'h0);
    end
    step();
    idle_inputs();
    #1;
    check("f2_req_cycles", req_cnt, 3);
    check("f2_req_dropped", mem_req, 0);
    check("f2_pc", pc, 32'h4);
    check("f2_imm", imm_sext, 32'hFFFF_FFFF);
    check("f2_funct", funct, 32'h3F);

    // PCSrc=1 with no stall, then with stall.
    PCSrc = 1; alu_out = 32'h100; PCWrite = 1;
    #1 check("j_nostall", stall, 0);
    step();
    check("j_pc", pc, 32'h100);
    IRWrite = 1; alu_out = 32'h200;
    #1 check("j_stall", stall, 1);
    step();
    check("j_pc_ignored", pc, 32'h100);
    mem_ready = 1; mem_rdata = 32'h012A_4020;
    step();
    idle_inputs();
    #1;
    check("j_pc_after", pc, 32'h200);
    check("r_op", Op, 0);
    check("r_funct", funct, 32'h20);
    check("r_rd", rd, 8);

    // A strobe in IDLE must be ignored.
    mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    check("idle_ready_ignored", instr, 32'h012A_4020);

    // Reset during the second WAIT cycle.
    IRWrite = 1;
    step(); step();
    reset = 0;
    #1;
    check("wr_mem_req", mem_req, 0);
    check("wr_pc", pc, 0);
    check("wr_instr", instr, 0);
    check("wr_stall", stall, 1);
    IRWrite = 0;
    step();
    reset = 1;
    step();
    check("wr_idle", mem_req, 0);

    // Load a non-zero instruction so a later NOP load is visible.
    IRWrite = 1;
    step();
    mem_ready = 1; mem_rdata = 32'hAAAA_5555;
    step();
    idle_inputs();
    check("pre_instr", instr, 32'hAAAA_5555);

`ifdef FETCH_TIMEOUT_EN
    IRWrite = 1;
    step();
    repeat (15) step();
    check("t_stall_released", stall, 0);
    check("t_mem_req", mem_req, 1);
    step();
    idle_inputs();
    check("t_nop", instr, 0);
    check("t_err", fetch_err, 1);
    check("t_idle", mem_req, 0);
    IRWrite = 1;
    step();
    mem_ready = 1; mem_rdata = 32'h1111_2222;
    step();
    idle_inputs();
    check("t_after_instr", instr, 32'h1111_2222);
    check("t_err_sticky", fetch_err, 1);
    reset = 0; #1 reset = 1;
    check("t_err_cleared", fetch_err, 0);
    IRWrite = 1;
    step();
    repeat (15) step();
    mem_ready = 1; mem_rdata = 32'h3333_4444;
    #1 check("t16_stall", stall, 0);
    step();
    idle_inputs();
    check("t16_instr", instr, 32'h3333_4444);
    check("t16_err", fetch_err, 0);
`else
    IRWrite = 1;
    step();
    repeat (19) step();
    check("nt_mem_req", mem_req, 1);
    check("nt_err", fetch_err, 0);
    check("nt_stall", stall, 1);
    mem_ready = 1; mem_rdata = 32'h5555_6666;
    step();
    idle_inputs();
    check("nt_instr", instr, 32'h5555_6666);
`endif

    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ir_unit.md
FETCH_IR_UNIT -- requirements
Module: fetch_ir_unit

Interface
REQ-001 SHALL provide ports: clk  in  1  clock, all state updates on rising edge.
REQ-002 SHALL provide ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide PCWrite  in  1  PC load request from control FSM.
REQ-004 SHALL provide IRWrite  in  1  instruction fetch/IR load request from control FSM.
REQ-005 SHALL provide PCSrc  in  1  next-PC select: 0 alu_result, 1 alu_out.
REQ-006 SHALL provide alu_result  in  32  combinational ALU output (PC+4 during fetch).
REQ-007 SHALL provide alu_out  in  32  registered ALUOut value.
REQ-008 SHALL provide mem_req  out  1  fetch request to instruction memory.
REQ-009 SHALL provide mem_addr  out  32  fetch address, always equal to pc.
REQ-010 SHALL provide mem_rdata  in  32  memory read data, valid when mem_ready=1.
REQ-011 SHALL provide mem_ready  in  1  memory completion strobe, one cycle.
REQ-012 SHALL provide stall  out  1  freeze request to control FSM state register.
REQ-013 SHALL provide pc  out  32  current program counter.
REQ-014 SHALL provide instr  out  32  instruction register contents.
REQ-015 SHALL provide Op  out  6  instr[31:26]; funct  out  6  instr[5:0]; rs/rt/rd  out  5 each  instr[25:21]/[20:16]/[15:11].
REQ-016 SHALL provide imm_sext  out  32  instr[15:0] sign-extended.
REQ-017 SHALL provide fetch_err  out  1  sticky fetch-timeout flag.

Function
REQ-018 SHALL implement FSM states IDLE and WAIT; mem_req=1 exactly when state=WAIT.
REQ-019 SHALL transition IDLE->WAIT on a clock edge where IRWrite=1; IRWrite in WAIT SHALL not restart the fetch.
REQ-020 SHALL drive stall = IRWrite AND NOT(state=WAIT AND mem_ready), combinationally.
REQ-021 SHALL, in WAIT with mem_ready=1, load instr<=mem_rdata and return to IDLE on that edge.
REQ-022 SHALL update pc <= (PCSrc ? alu_out : alu_result) only on edges where PCWrite=1 and stall=0; PCWrite with stall=1 SHALL be ignored.
REQ-023 SHALL hold pc, hence mem_addr, constant throughout WAIT.
REQ-024 SHALL ignore mem_ready and mem_rdata while in IDLE.
REQ-025 SHALL give minimum fetch latency of 2 cycles (IRWrite cycle in IDLE plus one WAIT cycle with mem_ready); each extra WAIT cycle adds one cycle.
REQ-026 SHALL decode Op, funct, rs, rt, rd, imm_sext combinationally from instr with no added latency.
REQ-027 SHALL leave instr unchanged when IRWrite=0.

Reset
REQ-028 SHALL, on reset=0, asynchronously force state=IDLE, pc=0x00000000, instr=0x00000000, fetch_err=0, timeout counter=0.
REQ-029 SHALL, when reset asserts during WAIT, drop mem_req immediately and discard any pending fetch.
REQ-030 SHALL drive all outputs from reset values (mem_req=0, Op=0, funct=0, imm_sext=0) while reset=0; stall follows IRWrite per REQ-020.

Configuration
REQ-031 SHALL, with macro FETCH_TIMEOUT_EN defined, count consecutive WAIT cycles without mem_ready in a 4-bit counter cleared on entry to WAIT.
REQ-032 SHALL, with FETCH_TIMEOUT_EN defined, on the 16th consecutive WAIT cycle without mem_ready, load instr<=0x00000000 (NOP), set fetch_err=1, force stall=0 that cycle, return to IDLE.
REQ-033 SHALL give mem_ready priority over timeout when both occur on the same cycle (normal load, fetch_err unchanged).
REQ-034 SHALL, without FETCH_TIMEOUT_EN, wait indefinitely in WAIT, omit the counter, and tie fetch_err to 0.

Verification
REQ-035 SHALL cover: reset, IRWrite=1 PCWrite=1 PCSrc=0 alu_result=0x4, mem_ready next cycle with rdata=0x20090005 -> instr=0x20090005, Op=0x08, rt=9, imm_sext=0x5, pc=0x4, stall high 1 cycle.
REQ-036 SHALL cover: 3-cycle memory wait -> mem_req high 3 cycles, mem_addr constant 0x0, pc unchanged until ready cycle.
REQ-037 SHALL cover: PCSrc=1 alu_out=0x100 with PCWrite, stall=0 -> pc=0x100; repeat with stall=1 -> pc unchanged.
REQ-038 SHALL cover: rdata=0x0000FFFF -> imm_sext=0xFFFFFFFF, funct=0x3F; rdata=0x012A4020 -> Op=0, funct=0x20, rd=8.
REQ-039 SHALL cover: reset asserted in WAIT cycle 2 -> mem_req=0 immediately, pc=0, instr=0, state IDLE.
REQ-040 SHALL cover (FETCH_TIMEOUT_EN): no mem_ready for 16 WAIT cycles -> instr=0, fetch_err=1 held until reset; ready on 16th cycle -> normal load, fetch_err=0.
